// File: rtl/inst_prefetch_queue.sv
`default_nettype none
// ============================================================================
// inst_prefetch_queue: sequential instruction fetch feeding a DEPTH-entry
// decode buffer; optional PREFETCH_BYPASS_EN forwards responses when empty.
// Revision: 1.0
// ============================================================================
module inst_prefetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      redirect_valid,
   input  logic [31:0]               redirect_pc,
   output logic                      inst_sram_en,
   output logic [31:0]               inst_sram_addr,
   input  logic [31:0]               inst_sram_rdata,
   output logic                      de_valid,
   input  logic                      de_ready,
   output logic [31:0]               de_pc,
   output logic [31:0]               de_inst,
   output logic [$clog2(DEPTH):0]    q_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          inflight_q, inflight_d;
   logic [31:0]   inflight_pc_q, inflight_pc_d;

   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   inst_mem [DEPTH];

   logic          issue;
   logic          resp;
   logic          push;
   logic          pop;
   logic          bypass_valid;
   logic          bypass_take;
   logic          buf_valid;
   logic [CW:0]   occupancy;
   logic          unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   // Occupancy counts the outstanding request so the buffer can never overflow.
   assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
   assign issue     = resetn && !redirect_valid && (occupancy < DEPTH_W);
   assign resp      = inflight_q && !redirect_valid;
   assign buf_valid = (count_q != '0);

`ifdef PREFETCH_BYPASS_EN
   assign bypass_valid = resp && !buf_valid;
`else
   assign bypass_valid = 1'b0;
`endif

   assign bypass_take = bypass_valid && de_ready;
   assign push        = resp && !bypass_take;
   assign pop         = buf_valid && de_ready && !redirect_valid;

   assign inst_sram_en   = issue;
   assign inst_sram_addr = fetch_pc_q;
   assign q_count        = count_q;
   assign de_valid       = buf_valid || bypass_valid;

   always_comb begin
      de_pc   = '0;
      de_inst = '0;
      if (buf_valid) begin
         de_pc   = pc_mem[rd_ptr_q];
         de_inst = inst_mem[rd_ptr_q];
      end else if (bypass_valid) begin
         de_pc   = inflight_pc_q;
         de_inst = inst_sram_rdata;
      end
   end

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d = count_q + CW'(push) - CW'(pop);
         if (issue) begin
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + 32'd4;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fetch_pc_q    <= RESET_PC;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   // Storage is never read while count is zero, so it needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_q]   <= inflight_pc_q;
         inst_mem[wr_ptr_q] <= inst_sram_rdata;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_inst_prefetch_queue.sv
`default_nettype none
// Testbench for inst_prefetch_queue: behavioural SRAM plus in-order PC scoreboard.
module tb_inst_prefetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
`ifdef PREFETCH_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        resetn;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_sram_en;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_rdata = '0;
   logic        de_valid;
   logic        de_ready;
   logic [31:0] de_pc;
   logic [31:0] de_inst;
   logic [2:0]  q_count;

   inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_rdata (inst_sram_rdata),
      .de_valid        (de_valid),
      .de_ready        (de_ready),
      .de_pc           (de_pc),
      .de_inst         (de_inst),
      .q_count         (q_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   logic [31:0] sb_pc[$];
   logic [31:0] exp_fetch = RESET_PC;
   logic        pend_en   = 1'b0;
   logic [31:0] pend_addr = '0;
   int          req_cnt   = 0;
   int          pop_cnt   = 0;

   // SRAM answers one cycle after the request.
   always @(posedge clk) begin
      #1;
      if (pend_en) inst_sram_rdata = mem_f(pend_addr);
   end

   // Scoreboard: requests push the expected PC, decode handshakes pop and compare.
   always @(negedge clk) begin
      if (resetn === 1'b1) begin
         if (redirect_valid) begin
            check("redir_no_req", 32'(inst_sram_en), 32'd0);
            sb_pc.delete();
            exp_fetch = {redirect_pc[31:2], 2'b00};
         end else begin
            if (de_valid && de_ready) begin
               check("sb_avail", 32'(sb_pc.size() != 0), 32'd1);
               if (sb_pc.size() != 0) begin
                  logic [31:0] e;
                  e = sb_pc.pop_front();
                  check("de_pc", de_pc, e);
                  check("de_inst", de_inst, mem_f(e));
                  pop_cnt++;
               end
            end
            if (inst_sram_en) begin
               check("fetch_addr", inst_sram_addr, exp_fetch);
               sb_pc.push_back(exp_fetch);
               exp_fetch = exp_fetch + 32'd4;
               req_cnt++;
            end
         end
      end
      pend_en   = inst_sram_en;
      pend_addr = inst_sram_addr;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int p0;
      resetn         = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      de_ready       = 1'b0;
      repeat (2) tick();
      check("rst_en", 32'(inst_sram_en), 32'd0);
      check("rst_de_valid", 32'(de_valid), 32'd0);
      check("rst_q_count", 32'(q_count), 32'd0);
      check("rst_de_pc", de_pc, 32'd0);
      check("rst_de_inst", de_inst, 32'd0);
      check("rst_addr", inst_sram_addr, RESET_PC);

      // Streaming with decode always ready
      de_ready = 1'b1;
      resetn   = 1'b1;
      @(negedge clk);
      check("first_req_en", 32'(inst_sram_en), 32'd1);
      check("first_req_addr", inst_sram_addr, RESET_PC);
      check("c0_de_valid", 32'(de_valid), 32'd0);
      @(negedge clk);
      check("c1_de_valid", 32'(de_valid), 32'(BYP));
      check("c1_de_pc", de_pc, BYP ? RESET_PC : 32'd0);
      @(negedge clk);
      check("c2_de_valid", 32'(de_valid), 32'd1);
      check("c2_de_pc", de_pc, BYP ? RESET_PC + 32'd4 : RESET_PC);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("stream_qcount_le1", 32'(q_count <= 3'd1), 32'd1);
         check("stream_de_valid", 32'(de_valid), 32'd1);
      end

      // Stall for 10 cycles from a freshly redirected, empty queue
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hBFC0_0200;
      de_ready       = 1'b0;
      tick();
      redirect_valid = 1'b0;
      req_cnt        = 0;
      repeat (10) @(negedge clk);
      check("stall_req_cnt", 32'(req_cnt), 32'(DEPTH));
      check("stall_q_count", 32'(q_count), 32'(DEPTH));
      check("stall_en", 32'(inst_sram_en), 32'd0);
      check("stall_head_pc", de_pc, 32'hBFC0_0200);
      check("stall_head_inst", de_inst, mem_f(32'hBFC0_0200));
      tick();
      de_ready = 1'b1;
      p0 = pop_cnt;
      repeat (6) @(negedge clk);
      check("drain_pops", 32'(pop_cnt - p0 >= DEPTH), 32'd1);

      // Fill, pop one, refill one in flight, then redirect with a pop
      tick();
      de_ready = 1'b0;
      repeat (6) @(negedge clk);
      check("fill_q_count", 32'(q_count), 32'(DEPTH));
      tick();
      de_ready = 1'b1;
      tick();
      de_ready = 1'b0;
      @(negedge clk);
      check("refill_q_count", 32'(q_count), 32'd3);
      check("refill_en", 32'(inst_sram_en), 32'd1);
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hBFC0_0103;
      de_ready       = 1'b1;
      @(negedge clk);
      check("redir_q_count", 32'(q_count), 32'd3);
      check("redir_de_valid", 32'(de_valid), 32'd1);
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      check("post_redir_de_valid", 32'(de_valid), 32'd0);
      check("post_redir_q_count", 32'(q_count), 32'd0);
      check("post_redir_en", 32'(inst_sram_en), 32'd1);
      check("post_redir_addr", inst_sram_addr, 32'hBFC0_0100);
      @(negedge clk);
      check("redir_t2_de_valid", 32'(de_valid), 32'(BYP));
      @(negedge clk);
      check("redir_t3_de_valid", 32'(de_valid), 32'd1);
      check("redir_t3_de_pc", de_pc, BYP ? 32'hBFC0_0104 : 32'hBFC0_0100);

      // Address wrap at the top of the address space
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFF8;
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      check("wrap_a0", inst_sram_addr, 32'hFFFF_FFF8);
      @(negedge clk);
      check("wrap_a1", inst_sram_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      check("wrap_a2", inst_sram_addr, 32'h0000_0000);
      repeat (4) @(negedge clk);

      // Asynchronous reset in the middle of a cycle
      @(posedge clk);
      #3;
      resetn = 1'b0;
      sb_pc.delete();
      exp_fetch = RESET_PC;
      #1;
      check("async_rst_en", 32'(inst_sram_en), 32'd0);
      check("async_rst_de_valid", 32'(de_valid), 32'd0);
      check("async_rst_q_count", 32'(q_count), 32'd0);
      check("async_rst_de_pc", de_pc, 32'd0);
      check("async_rst_de_inst", de_inst, 32'd0);
      repeat (2) tick();
      resetn = 1'b1;
      @(negedge clk);
      check("restart_en", 32'(inst_sram_en), 32'd1);
      check("restart_addr", inst_sram_addr, RESET_PC);
      p0 = pop_cnt;
      repeat (8) @(negedge clk);
      check("restart_pops", 32'(pop_cnt - p0 >= 5), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
